// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared types and helpers for the register-file arbiter.
//   arb_state_e  - arbiter state (IDLE / LOCKED)
//   rf_addr_w()  - address width helper, clog2(n) with a floor of 1 bit
//   RF_AW_DEF    - address width for the default register count
package reg_file_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // A width of at least 1 keeps single-entry configurations legal.
  function automatic int rf_addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int RF_N_REG_DEF = 8;
  localparam int RF_AW_DEF    = rf_addr_w(RF_N_REG_DEF);

endpackage

// File: rtl/reg_file_arbiter_rr_pick.sv
// rr_pick: wrap-around priority search.
//   req    - request vector
//   rr_ptr - index with highest priority this cycle
//   pick   - one-hot; first requesting index at or above rr_ptr, modulo N_REQ
module rr_pick
  import reg_file_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int PW    = rf_addr_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] pick
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PW'((int'(rr_ptr) + k) % N_REQ);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_file_arbiter.sv
// reg_file_arbiter: round-robin arbiter with lock support in front of a
// single-port register file. Address N_REG-1 is a read-only external input.
//   clk, rst           - clock, asynchronous active-high reset
//   req/we/lock        - per-requester request, write enable, ownership hold
//   addr/wdata         - per-requester address and write data
//   gnt                - combinational one-hot grant
//   rvalid/rdata       - registered read strobe (one-hot) and shared read data
//   ro_err             - registered pulse after a write to the read-only address
//   lock_timeout       - registered pulse after a forced lock release
//   rf_a/rf_ce/rf_in   - register-file address, write enable, write data
//   rf_out             - register-file read data (combinational from rf_a)
module reg_file_arbiter
  import reg_file_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int N_REG    = 8,
  parameter  int N_REQ    = 2,
  parameter  int LOCK_MAX = 16,
  localparam int AW       = rf_addr_w(N_REG),
  localparam int PW       = rf_addr_w(N_REQ),
  localparam int CW       = $clog2(LOCK_MAX) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            we,
  input  logic [N_REQ-1:0]            lock,
  input  logic [N_REQ-1:0][AW-1:0]    addr,
  input  logic [N_REQ-1:0][WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            rvalid,
  output logic [WIDTH-1:0]            rdata,
  output logic                        ro_err,
  output logic                        lock_timeout,
  output logic [AW-1:0]               rf_a,
  output logic                        rf_ce,
  output logic [WIDTH-1:0]            rf_in,
  input  logic [WIDTH-1:0]            rf_out
);

  localparam logic [AW-1:0] RO_ADDR = AW'(N_REG - 1);

  arb_state_e         state_q, state_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [CW-1:0]      lock_cnt_q, lock_cnt_d;
  // Set on a forced release; blocks re-locking until lock is seen low.
  logic [N_REQ-1:0]   blk_q, blk_d;
  logic [WIDTH-1:0]   rdata_q, rdata_d;
  logic [N_REQ-1:0]   rvalid_q, rvalid_d;
  logic               ro_err_q, ro_err_d;
  logic               lock_timeout_q, lock_timeout_d;

  logic [PW-1:0]      ptr_sel, pick_idx, gsel;
  logic [N_REQ-1:0]   pick;
  logic               arb, any_gnt, ro_hit, rd_hit;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] i);
    return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // Releasing a lock arbitrates in the same cycle, starting after the owner.
  assign ptr_sel = (state_q == IDLE) ? rr_ptr_q : nxt(owner_q);

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req   (req),
    .rr_ptr(ptr_sel),
    .pick  (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (pick[i]) pick_idx = PW'(i);
  end

  // Arbitration / lock state
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    owner_d        = owner_q;
    lock_cnt_d     = lock_cnt_q;
    blk_d          = blk_q & lock;
    lock_timeout_d = 1'b0;
    gnt            = '0;
    arb            = (state_q == IDLE) || !lock[owner_q];
    gsel           = arb ? pick_idx : owner_q;

    if (arb) begin
      state_d = IDLE;
      if (state_q == LOCKED) rr_ptr_d = nxt(owner_q);
      gnt = pick;
      if (|pick) begin
        rr_ptr_d = nxt(pick_idx);
        if (lock[pick_idx] && !blk_q[pick_idx]) begin
          state_d    = LOCKED;
          owner_d    = pick_idx;
          lock_cnt_d = '0;
        end
      end
    end else begin
      // Owner keeps the port even while its req is low; those cycles count.
      gnt[owner_q] = req[owner_q];
      lock_cnt_d   = lock_cnt_q + CW'(1);
      if (int'(lock_cnt_q) + 1 == LOCK_MAX - 1) begin
        state_d        = IDLE;
        rr_ptr_d       = nxt(owner_q);
        lock_timeout_d = 1'b1;
        blk_d[owner_q] = 1'b1;
      end
    end

    if (rst) gnt = '0;
  end

  // Register-file port and read capture
  always_comb begin
    any_gnt = |gnt;
    rf_a    = '0;
    rf_in   = '0;
    rf_ce   = 1'b0;
    ro_hit  = 1'b0;
    rd_hit  = 1'b0;
    if (any_gnt) begin
      rf_a   = addr[gsel];
      rf_in  = wdata[gsel];
      ro_hit = we[gsel] && (addr[gsel] == RO_ADDR);
      rf_ce  = we[gsel] && !ro_hit;
      rd_hit = !we[gsel];
    end
    rdata_d  = rd_hit ? rf_out : rdata_q;
    rvalid_d = rd_hit ? gnt : '0;
    ro_err_d = ro_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      owner_q        <= '0;
      lock_cnt_q     <= '0;
      blk_q          <= '0;
      rdata_q        <= '0;
      rvalid_q       <= '0;
      ro_err_q       <= 1'b0;
      lock_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      owner_q        <= owner_d;
      lock_cnt_q     <= lock_cnt_d;
      blk_q          <= blk_d;
      rdata_q        <= rdata_d;
      rvalid_q       <= rvalid_d;
      ro_err_q       <= ro_err_d;
      lock_timeout_q <= lock_timeout_d;
    end
  end

  assign rdata        = rdata_q;
  assign rvalid       = rvalid_q;
  assign ro_err       = ro_err_q;
  assign lock_timeout = lock_timeout_q;

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Self-checking bench for reg_file_arbiter: directed scenarios plus random
// traffic, compared every cycle against a behavioural model.
module tb_reg_file_arbiter;

  localparam int WIDTH    = 8;
  localparam int N_REG    = 8;
  localparam int N_REQ    = 2;
  localparam int LOCK_MAX = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req, we, lock;
  logic [1:0][2:0] addr;
  logic [1:0][7:0] wdata;
  logic [1:0]      gnt, rvalid;
  logic [7:0]      rdata, rf_in, rf_out, ext_in;
  logic            ro_err, lock_timeout, rf_ce;
  logic [2:0]      rf_a;
  logic [7:0]      rf_mem [0:7];

  reg_file_arbiter #(
    .WIDTH(WIDTH), .N_REG(N_REG), .N_REQ(N_REQ), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock), .addr(addr),
    .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ro_err(ro_err), .lock_timeout(lock_timeout), .rf_a(rf_a),
    .rf_ce(rf_ce), .rf_in(rf_in), .rf_out(rf_out)
  );

  always #5 clk = ~clk;

  // External register file; the top address reads the user input.
  assign rf_out = (rf_a == 3'd7) ? ext_in : rf_mem[rf_a];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= '0;
    end else if (rf_ce) begin
      rf_mem[rf_a] <= rf_in;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  // Model state: who owns the port and for how many cycles it has held it.
  bit         m_locked;
  int         m_owner, m_own, m_ptr, m_g;
  bit         m_blk [N_REQ];
  logic [7:0] m_mem [8];
  logic [7:0] m_rdata;
  logic [1:0] m_rvalid;
  bit         m_ro, m_to;
  logic [1:0] obs_gnt;
  logic       obs_ce;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_locked = 0; m_owner = 0; m_own = 0; m_ptr = 0;
    for (int i = 0; i < N_REQ; i++) m_blk[i] = 0;
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
    m_rdata = '0; m_rvalid = '0; m_ro = 0; m_to = 0;
  endtask

  task automatic m_eval();
    int s, i;
    m_g = -1;
    if (rst) return;
    if (m_locked && lock[m_owner]) begin
      if (req[m_owner]) m_g = m_owner;
    end else begin
      s = m_locked ? (m_owner + 1) % N_REQ : m_ptr;
      for (int k = 0; k < N_REQ; k++) begin
        i = (s + k) % N_REQ;
        if (m_g < 0 && req[i]) m_g = i;
      end
    end
  endtask

  task automatic m_update();
    bit nb [N_REQ];
    for (int i = 0; i < N_REQ; i++) nb[i] = m_blk[i] && lock[i];
    m_ro = 0; m_to = 0; m_rvalid = '0;
    if (m_g >= 0) begin
      if (we[m_g]) begin
        if (addr[m_g] == 3'd7) m_ro = 1;
        else m_mem[addr[m_g]] = wdata[m_g];
      end else begin
        m_rdata  = (addr[m_g] == 3'd7) ? ext_in : m_mem[addr[m_g]];
        m_rvalid = 2'(1 << m_g);
      end
    end
    if (m_locked && lock[m_owner]) begin
      m_own++;
      if (m_own == LOCK_MAX) begin
        m_locked = 0; m_ptr = (m_owner + 1) % N_REQ; m_to = 1; nb[m_owner] = 1;
      end
    end else begin
      if (m_locked) begin m_locked = 0; m_ptr = (m_owner + 1) % N_REQ; end
      if (m_g >= 0) begin
        m_ptr = (m_g + 1) % N_REQ;
        if (lock[m_g] && !m_blk[m_g]) begin
          m_locked = 1; m_owner = m_g; m_own = 1;
        end
      end
    end
    for (int i = 0; i < N_REQ; i++) m_blk[i] = nb[i];
  endtask

  // One clock cycle: drive at negedge, check mid-cycle, advance model at posedge.
  task automatic cyc(input bit r, input logic [1:0] rq, input logic [1:0] w,
                     input logic [1:0] lk, input logic [2:0] a0, input logic [2:0] a1,
                     input logic [7:0] d0, input logic [7:0] d1);
    logic [1:0] e_gnt;
    logic       e_ce;
    logic [2:0] e_a;
    logic [7:0] e_in;
    rst = r; req = rq; we = w; lock = lk;
    addr[0] = a0; addr[1] = a1; wdata[0] = d0; wdata[1] = d1;
    if (r) m_reset();
    #1;
    m_eval();
    e_gnt = '0; e_ce = 1'b0; e_a = '0; e_in = '0;
    if (m_g >= 0) begin
      e_gnt = 2'(1 << m_g);
      e_a   = addr[m_g];
      e_in  = wdata[m_g];
      e_ce  = we[m_g] && (addr[m_g] != 3'd7);
    end
    chk("gnt",          32'(gnt),          32'(e_gnt));
    chk("rf_ce",        32'(rf_ce),        32'(e_ce));
    chk("rf_a",         32'(rf_a),         32'(e_a));
    chk("rf_in",        32'(rf_in),        32'(e_in));
    chk("rvalid",       32'(rvalid),       32'(m_rvalid));
    chk("rdata",        32'(rdata),        32'(m_rdata));
    chk("ro_err",       32'(ro_err),       32'(m_ro));
    chk("lock_timeout", 32'(lock_timeout), 32'(m_to));
    obs_gnt = gnt;
    obs_ce  = rf_ce;
    @(posedge clk);
    if (!r) m_update();
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] exp_seq [4];
    logic [1:0] lk_r;
    int n_to;
    rst = 1'b1; req = '0; we = '0; lock = '0; addr = '0; wdata = '0; ext_in = '0;
    m_reset();
    @(negedge clk);
    @(negedge clk);

    // Reset state
    cyc(1, 2'b11, 2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00);
    chk("rst_gnt", 32'(obs_gnt), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);

    // Contention after reset: strict alternation
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 2'b11, 2'b00, 2'b00, 3'd0, 3'd1, 8'h00, 8'h00);
      chk("rr_seq", 32'(obs_gnt), 32'(exp_seq[i]));
    end

    // Write then read back
    cyc(0, 2'b01, 2'b01, 2'b00, 3'd3, 3'd0, 8'h5A, 8'h00);
    chk("wr_ce", 32'(obs_ce), 32'd1);
    cyc(0, 2'b01, 2'b00, 2'b00, 3'd3, 3'd0, 8'h00, 8'h00);
    chk("rd_rvalid", 32'(rvalid), 32'h1);
    chk("rd_rdata", 32'(rdata), 32'h5A);

    // Lock by req1 while req0 waits, then release hands the port to req0
    for (int i = 0; i < 5; i++) begin
      cyc(0, 2'b11, 2'b00, 2'b10, 3'd1, 3'd2, 8'h00, 8'h00);
      chk("lock_gnt", 32'(obs_gnt), 32'h2);
    end
    cyc(0, 2'b11, 2'b00, 2'b00, 3'd1, 3'd2, 8'h00, 8'h00);
    chk("unlock_gnt", 32'(obs_gnt), 32'h1);

    // Lock held past LOCK_MAX: one timeout, then req0 served
    n_to = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 2'b11, 2'b00, 2'b10, 3'd4, 3'd5, 8'h00, 8'h00);
      if (i == 16) chk("post_to_gnt", 32'(obs_gnt), 32'h1);
      if (lock_timeout) n_to++;
    end
    chk("to_pulses", 32'(n_to), 32'd1);
    cyc(0, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00);

    // Read-only register
    cyc(0, 2'b01, 2'b01, 2'b00, 3'd7, 3'd0, 8'hFF, 8'h00);
    chk("ro_ce", 32'(obs_ce), 32'd0);
    chk("ro_err", 32'(ro_err), 32'd1);
    ext_in = 8'hC3;
    cyc(0, 2'b01, 2'b00, 2'b00, 3'd7, 3'd0, 8'h00, 8'h00);
    chk("ro_rdata", 32'(rdata), 32'hC3);

    // Reset during a locked read
    cyc(0, 2'b01, 2'b00, 2'b01, 3'd2, 3'd0, 8'h00, 8'h00);
    cyc(0, 2'b01, 2'b00, 2'b01, 3'd2, 3'd0, 8'h00, 8'h00);
    cyc(1, 2'b01, 2'b00, 2'b01, 3'd2, 3'd0, 8'h00, 8'h00);
    chk("rstlk_gnt", 32'(obs_gnt), 32'd0);
    chk("rstlk_rvalid", 32'(rvalid), 32'd0);
    cyc(0, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00);
    chk("rstlk_norv", 32'(rvalid), 32'd0);
    cyc(0, 2'b11, 2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00);
    chk("rstlk_next", 32'(obs_gnt), 32'h1);

    // Random traffic; lock bits are sticky so timeouts occur
    lk_r = '0;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 2; b++)
        if ($urandom_range(0, 7) == 0) lk_r[b] = ~lk_r[b];
      if ($urandom_range(0, 3) == 0) ext_in = 8'($urandom);
      cyc(($urandom_range(0, 99) == 0), 2'($urandom), 2'($urandom), lk_r,
          3'($urandom), 3'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_arbiter.md
REG_FILE_ARBITER -- requirements
Module: reg_file_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register data width.
REQ-002 SHALL have parameter N_REG, default 8, register count; address N_REG-1 is the read-only external input register.
REQ-003 SHALL have parameter N_REQ, default 2, number of requesters.
REQ-004 SHALL have parameter LOCK_MAX, default 16, maximum consecutive locked cycles.
REQ-005 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port req  input  N_REQ  per-requester access request.
REQ-008 SHALL have port we  input  N_REQ  per-requester write enable; 0 means read.
REQ-009 SHALL have port lock  input  N_REQ  per-requester ownership hold.
REQ-010 SHALL have port addr  input  N_REQ x clog2(N_REG)  per-requester register address.
REQ-011 SHALL have port wdata  input  N_REQ x WIDTH  per-requester write data.
REQ-012 SHALL have port gnt  output  N_REQ  one-hot grant, combinational.
REQ-013 SHALL have port rvalid  output  N_REQ  one-hot registered read-data strobe.
REQ-014 SHALL have port rdata  output  WIDTH  registered read data, shared.
REQ-015 SHALL have port ro_err  output  1  registered pulse on a granted write to address N_REG-1.
REQ-016 SHALL have port lock_timeout  output  1  registered pulse on forced lock release.
REQ-017 SHALL have ports rf_a (clog2(N_REG)), rf_ce (1) and rf_in (WIDTH) as outputs, and rf_out (WIDTH) as an input, forming the register-file port.

Function
REQ-018 SHALL assert at most one gnt bit per cycle, and only for a requester with req=1.
REQ-019 SHALL drive rf_a=addr[g] and rf_in=wdata[g], and drive rf_ce=we[g], for the granted requester g; with no grant, rf_ce SHALL be 0 and rf_a/rf_in 0.
REQ-020 SHALL suppress rf_ce for a write to N_REG-1 and pulse ro_err the next cycle.
REQ-021 SHALL commit a write at the rising edge ending the grant cycle.
REQ-022 SHALL capture rf_out into rdata at the edge ending a read grant cycle, and raise rvalid[g] for exactly the next cycle (1-cycle latency).
REQ-023 SHALL hold rdata between reads; rdata is unaffected by writes.
REQ-024 SHALL implement states IDLE and LOCKED.
REQ-025 In IDLE, SHALL grant the first requesting index at or above rr_ptr, searching with wrap-around modulo N_REQ.
REQ-026 On every IDLE grant to g, SHALL set rr_ptr=(g+1) mod N_REQ.
REQ-027 In IDLE, a grant to g with lock[g]=1 SHALL transition to LOCKED with owner=g and lock_cnt=0.
REQ-028 In LOCKED, SHALL grant only owner (when req[owner]=1), and other requests SHALL wait.
REQ-029 In LOCKED, lock[owner]=0 SHALL return to IDLE in the same cycle, with arbitration per REQ-025 and rr_ptr=(owner+1) mod N_REQ.
REQ-030 In LOCKED, lock_cnt SHALL increment each cycle; on reaching LOCK_MAX-1 it SHALL force IDLE, set rr_ptr=(owner+1) mod N_REQ and pulse lock_timeout next cycle.
REQ-031 After a forced release, the same requester SHALL NOT re-lock until it has deasserted lock for at least one cycle.
REQ-032 Simultaneous req on all inputs SHALL yield strict rotation: each requester is granted once per N_REQ grants.
REQ-033 A requester dropping req mid-LOCKED while holding lock SHALL keep ownership; cycles without req SHALL count toward LOCK_MAX.

Reset
REQ-034 On rst SHALL set state=IDLE, rr_ptr=0, owner=0, lock_cnt=0, rdata=0, rvalid=0, ro_err=0, lock_timeout=0, and gnt/rf_ce SHALL be 0 while rst is high.
REQ-035 A reset mid-lock or mid-read SHALL abandon the access with no rvalid pulse afterwards.

Structure
REQ-036 SHALL place an arb_state_e typedef (IDLE, LOCKED) in shared package reg_file_pkg.
REQ-037 SHALL place an address-width helper constant (clog2 of N_REG) in reg_file_pkg.
REQ-038 SHALL implement the wrap-around priority search as one sub-module rr_pick (inputs req, rr_ptr; output one-hot pick).

Verification
REQ-039 Write then read: req0 writes 0x5A to addr 3, then req0 reads addr 3 -> rvalid[0] one cycle after the grant, rdata=0x5A.
REQ-040 Contention: req=2'b11 held for 4 cycles after reset -> gnt sequence 01,10,01,10.
REQ-041 Lock: req1 with lock=1 for 5 cycles while req0 is asserted -> gnt=10 for all 5 cycles; gnt=01 on the cycle lock1 drops.
REQ-042 Timeout: lock1 held for 20 cycles with LOCK_MAX=16 -> lock_timeout pulse once, then gnt=01 when req0 pending.
REQ-043 Read-only: req0 writes 0xFF to addr 7 -> rf_ce=0, ro_err pulse; a later read of addr 7 returns the user input value.
REQ-044 Reset mid-lock: rst asserted during LOCKED read grant -> all outputs 0, rvalid never pulses, the next grant goes to req0.
